// File: rtl/ring_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ring_arb_pkg
// Shared types and helpers for the ring arbiter:
//   state_t    - arbiter FSM states (IDLE, GRANT)
//   onehot_enc - one-hot vector to binary index
//   ring_rotl  - rotate an n-bit one-hot ring left by one position
// Helpers work on a fixed MAX_N-bit container; callers size-cast in and out.
// ---------------------------------------------------------------------------
package ring_arb_pkg;

    localparam int unsigned MAX_N = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Returns the index of the set bit of a one-hot vector (0 for all-zero).
    function automatic int unsigned onehot_enc(input logic [MAX_N-1:0] v);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAX_N; i++) begin
            if (v[i]) idx = idx | i;
        end
        return idx;
    endfunction

    // Rotates the low n bits of v left by one, wrapping bit n-1 into bit 0.
    // Bits at and above n are returned as zero.
    function automatic logic [MAX_N-1:0] ring_rotl(input logic [MAX_N-1:0] v,
                                                   input int unsigned     n);
        logic [MAX_N-1:0] r;
        r    = '0;
        r[0] = v[n-1];
        for (int i = 1; i < MAX_N; i++) begin
            if (i < n) r[i] = v[i-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/ring_arbiter_if.sv
// ---------------------------------------------------------------------------
// ring_arbiter_if
// Bundle between requesters and the ring arbiter.
//   req      requesters -> arbiter  level requests, one bit per requester
//   grant    arbiter -> requesters  registered one-hot grant
//   grant_id arbiter -> requesters  binary index of the owner
//   busy     arbiter -> requesters  any grant bit set
//   preempt  arbiter -> requesters  first cycle of a grant won by preemption
//   ptr      arbiter -> requesters  one-hot priority ring (debug)
// master: requester side.  slave: arbiter side.
// ---------------------------------------------------------------------------
interface ring_arbiter_if #(
    parameter int unsigned N = 4
);
    localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   req;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           busy;
    logic           preempt;
    logic [N-1:0]   ptr;

    modport master (
        output req,
        input  grant, grant_id, busy, preempt, ptr
    );

    modport slave (
        input  req,
        output grant, grant_id, busy, preempt, ptr
    );

endinterface

// File: rtl/ring_arbiter_pick.sv
// ---------------------------------------------------------------------------
// ring_pick
// Combinational masked priority picker. Chooses the first set bit of
// (i_req & ~i_excl) at or after the one-hot i_ptr position, searching upward
// and wrapping from N-1 to 0.
//   i_req   N  request vector
//   i_ptr   N  one-hot search start
//   i_excl  N  bits excluded from the search (current owner on preempt)
//   o_pick  N  one-hot pick (zero when nothing eligible)
//   o_found 1  some eligible request exists
// ---------------------------------------------------------------------------
module ring_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] i_req,
    input  logic [N-1:0] i_ptr,
    input  logic [N-1:0] i_excl,
    output logic [N-1:0] o_pick,
    output logic         o_found
);

    logic [N-1:0] w_req;
    logic [N-1:0] w_ge_mask;
    logic [N-1:0] w_hi;
    logic [N-1:0] w_sel;

    assign w_req     = i_req & ~i_excl;
    // Bits at or above the one-hot pointer: ~(ptr - 1).
    assign w_ge_mask = ~(i_ptr - N'(1));
    assign w_hi      = w_req & w_ge_mask;
    // Upper segment wins; otherwise wrap around to the lowest request.
    assign w_sel     = (|w_hi) ? w_hi : w_req;
    // Isolate the lowest set bit.
    assign o_pick    = w_sel & (~w_sel + N'(1));
    assign o_found   = |w_req;

endmodule

// File: rtl/ring_arbiter.sv
// ---------------------------------------------------------------------------
// ring_arbiter
// Round-robin arbiter with a one-hot rotating priority ring, hold-until-
// release ownership and bounded tenure (preempt after MAX_HOLD cycles when
// another requester waits). All outputs are registered.
//   clk  1  rising-edge clock
//   rst  1  asynchronous active-low reset
//   bus     ring_arbiter_if.slave (req in; grant, grant_id, busy, preempt,
//           ptr out)
// Parameters: N (2..32) requesters, MAX_HOLD (>=1) tenure limit.
// ---------------------------------------------------------------------------
module ring_arbiter
    import ring_arb_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst,
    ring_arbiter_if.slave bus
);

    localparam int unsigned CW  = $clog2(MAX_HOLD + 1);
    localparam int unsigned IDW = $clog2(N);

    state_t         r_state,   w_nx_state;
    logic [N-1:0]   r_grant,   w_nx_grant;
    logic [N-1:0]   r_ptr,     w_nx_ptr;
    logic [CW-1:0]  r_cnt,     w_nx_cnt;
    logic           r_preempt, w_nx_preempt;
    logic [IDW-1:0] r_grant_id;
    logic           r_busy;

    logic [N-1:0]   w_ring_next;
    logic [N-1:0]   w_base;
    logic [N-1:0]   w_excl;
    logic [N-1:0]   w_pick;
    logic           w_found;
    logic           w_owner_req;

    // Position just after the current owner: the ring start for a release
    // or preempt.
    assign w_ring_next = N'(ring_rotl(MAX_N'(r_grant), N));
    assign w_owner_req = |(bus.req & r_grant);

    // While owned, the pick is evaluated from the owner's successor with the
    // owner masked out, so one picker serves idle, release and preempt.
    assign w_base = (r_state == GRANT) ? w_ring_next : r_ptr;
    assign w_excl = (r_state == GRANT) ? r_grant     : '0;

    ring_pick #(.N(N)) u_pick (
        .i_req   (bus.req),
        .i_ptr   (w_base),
        .i_excl  (w_excl),
        .o_pick  (w_pick),
        .o_found (w_found)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        w_nx_state   = r_state;
        w_nx_grant   = r_grant;
        w_nx_ptr     = r_ptr;
        w_nx_cnt     = r_cnt;
        w_nx_preempt = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_nx_grant = w_pick;
                    w_nx_cnt   = CW'(1);
                    w_nx_state = GRANT;
                end
            end

            GRANT: begin
                if (w_owner_req) begin
                    if (r_cnt < CW'(MAX_HOLD)) begin
                        w_nx_cnt = r_cnt + CW'(1);
                    end else if (w_found) begin
                        w_nx_ptr     = w_ring_next;
                        w_nx_grant   = w_pick;
                        w_nx_cnt     = CW'(1);
                        w_nx_preempt = 1'b1;
                    end else begin
                        // Nobody waiting: restart the tenure window.
                        w_nx_cnt = CW'(1);
                    end
                end else begin
                    w_nx_ptr = w_ring_next;
                    if (w_found) begin
                        // Hand over in the same edge, no idle bubble.
                        w_nx_grant = w_pick;
                        w_nx_cnt   = CW'(1);
                    end else begin
                        w_nx_grant = '0;
                        w_nx_cnt   = '0;
                        w_nx_state = IDLE;
                    end
                end
            end

            default: begin
                w_nx_state = IDLE;
                w_nx_grant = '0;
                w_nx_cnt   = '0;
            end
        endcase
    end

    // NOTE: all state sits in this one block and uses non-blocking
    // assignments, so every register samples pre-edge values; every register
    // is a small flop with a defined reset value (there is no memory here).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_ptr      <= N'(1);
            r_cnt      <= '0;
            r_preempt  <= 1'b0;
            r_grant_id <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_nx_state;
            r_grant    <= w_nx_grant;
            r_ptr      <= w_nx_ptr;
            r_cnt      <= w_nx_cnt;
            r_preempt  <= w_nx_preempt;
            r_grant_id <= IDW'(onehot_enc(MAX_N'(w_nx_grant)));
            r_busy     <= |w_nx_grant;
        end
    end

    assign bus.grant    = r_grant;
    assign bus.grant_id = r_grant_id;
    assign bus.busy     = r_busy;
    assign bus.preempt  = r_preempt;
    assign bus.ptr      = r_ptr;

endmodule

// File: tb/tb_ring_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ring_arbiter
// Self-checking bench for ring_arbiter (N=4, MAX_HOLD=4). An index-based
// reference model predicts every registered output; predictions are queued
// when a request vector is driven and compared after the clock edge.
// ---------------------------------------------------------------------------
module tb_ring_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 4;

    typedef struct {
        logic [3:0] grant;
        logic [1:0] grant_id;
        logic       busy;
        logic       preempt;
        logic [3:0] ptr;
    } exp_t;

    logic clk;
    logic rst;

    ring_arbiter_if #(.N(N)) bus ();

    ring_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    exp_t sb[$];

    // Reference model state: owner index (-1 when idle), tenure count,
    // ring pointer index.
    int m_owner;
    int m_cnt;
    int m_ptr;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int model_pick(input logic [3:0] r, input int start,
                                      input int excl);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (start + k) % N;
            if (r[idx] && idx != excl) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_ptr   = 0;
    endtask

    task automatic model_step(input logic [3:0] r);
        exp_t e;
        int   p;
        logic pre;
        pre = 1'b0;
        if (m_owner < 0) begin
            p = model_pick(r, m_ptr, -1);
            if (p >= 0) begin
                m_owner = p;
                m_cnt   = 1;
            end
        end else if (r[m_owner]) begin
            if (m_cnt < MAX_HOLD) begin
                m_cnt++;
            end else begin
                p = model_pick(r, (m_owner + 1) % N, m_owner);
                if (p >= 0) begin
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = p;
                    pre     = 1'b1;
                end
                m_cnt = 1;
            end
        end else begin
            m_ptr = (m_owner + 1) % N;
            p     = model_pick(r, m_ptr, m_owner);
            if (p >= 0) begin
                m_owner = p;
                m_cnt   = 1;
            end else begin
                m_owner = -1;
                m_cnt   = 0;
            end
        end
        e.grant    = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        e.grant_id = (m_owner < 0) ? 2'd0 : 2'(m_owner);
        e.busy     = (m_owner >= 0);
        e.preempt  = pre;
        e.ptr      = 4'(1 << m_ptr);
        sb.push_back(e);
    endtask

    // Drive one request vector for one clock edge and score the outputs.
    task automatic cycle(input logic [3:0] r);
        exp_t e;
        bus.req = r;
        model_step(r);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check("grant",    32'(bus.grant),    32'(e.grant));
            check("grant_id", 32'(bus.grant_id), 32'(e.grant_id));
            check("busy",     32'(bus.busy),     32'(e.busy));
            check("preempt",  32'(bus.preempt),  32'(e.preempt));
            check("ptr",      32'(bus.ptr),      32'(e.ptr));
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [3:0] exp_seq [4];
        int         n_pre;

        // 1. Reset with all requests high.
        rst     = 1'b0;
        bus.req = 4'b1111;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant",    32'(bus.grant),    32'h0);
        check("rst_busy",     32'(bus.busy),     32'h0);
        check("rst_ptr",      32'(bus.ptr),      32'h1);
        check("rst_grant_id", 32'(bus.grant_id), 32'h0);
        check("rst_preempt",  32'(bus.preempt),  32'h0);
        @(negedge clk);
        rst = 1'b1;

        // 2. Single request, then drop.
        cycle(4'b0000);
        cycle(4'b0100);
        check("single_grant", 32'(bus.grant),    32'h4);
        check("single_id",    32'(bus.grant_id), 32'd2);
        cycle(4'b0100);
        cycle(4'b0100);
        cycle(4'b0000);
        check("drop_grant", 32'(bus.grant), 32'h0);
        check("drop_ptr",   32'(bus.ptr),   32'h8);
        cycle(4'b0000);

        // 3. Rotation: each owner drops after two grant cycles.
        do_reset();
        exp_seq[0] = 4'b0010;
        exp_seq[1] = 4'b0100;
        exp_seq[2] = 4'b1000;
        exp_seq[3] = 4'b0001;
        cycle(4'b1111);
        check("rot_first", 32'(bus.grant), 32'h1);
        for (int i = 0; i < 4; i++) begin
            logic [3:0] drop;
            cycle(4'b1111);
            drop = 4'b1111 & ~bus.grant;
            cycle(drop);
            check("rot_seq",  32'(bus.grant), 32'(exp_seq[i]));
            check("rot_busy", 32'(bus.busy),  32'h1);
        end

        // 4. Preemption with two constant requesters.
        do_reset();
        n_pre = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(4'b0011);
            if (bus.preempt) n_pre++;
            if (i == 3) check("pre_hold0", 32'(bus.grant), 32'h1);
            if (i == 4) check("pre_take1", 32'(bus.grant), 32'h2);
            if (i == 8) check("pre_back0", 32'(bus.grant), 32'h1);
        end
        check("pre_count", 32'(n_pre), 32'd2);

        // 5. Solo overrun: no preempt, ptr untouched.
        do_reset();
        n_pre = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(4'b1000);
            if (bus.preempt) n_pre++;
        end
        check("solo_pre",   32'(n_pre),     32'd0);
        check("solo_grant", 32'(bus.grant), 32'h8);
        check("solo_ptr",   32'(bus.ptr),   32'h1);

        // 6. Asynchronous reset mid-grant.
        do_reset();
        cycle(4'b0010);
        cycle(4'b0010);
        check("ar_pre_grant", 32'(bus.grant), 32'h2);
        #3;
        rst = 1'b0;
        #1;
        check("ar_grant",   32'(bus.grant),    32'h0);
        check("ar_busy",    32'(bus.busy),     32'h0);
        check("ar_ptr",     32'(bus.ptr),      32'h1);
        check("ar_id",      32'(bus.grant_id), 32'h0);
        #2;
        rst = 1'b1;
        model_reset();
        cycle(4'b0010);
        check("ar_regrant", 32'(bus.grant), 32'h2);
        check("ar_ptr2",    32'(bus.ptr),   32'h1);
        cycle(4'b0000);

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ring_arbiter.md
# ring_arbiter

Round-robin arbiter that shares one resource among `N` requesters using a one-hot rotating priority ring, the same token-passing structure as our ring counters. Registered one-hot grant, hold until the owner releases, and bounded tenure: a preempt after `MAX_HOLD` cycles when others are waiting. Sits between requester blocks and any shared datapath resource (bus, counter, shifter) as its single point of access control.

## Interface
- `N`, default 4: number of requesters, minimum 2.
- `MAX_HOLD`, default 8: maximum consecutive grant cycles while another requester waits, minimum 1.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: asynchronous, active-low reset.
- `req`  in  N: level requests, one bit per requester.
- `grant`  out  N: registered one-hot grant; all zeros when no owner.
- `grant_id`  out  clog2(N): binary index of the owner; 0 when idle.
- `busy`  out  1: high while any grant bit is set.
- `preempt`  out  1: one-cycle pulse in the first cycle of a grant obtained by preemption.
- `ptr`  out  N: one-hot priority ring, for debug.

## Operation
- Reset values: `grant` = 0, `grant_id` = 0, `busy` = 0, `preempt` = 0, `ptr` = one-hot bit 0, state IDLE, hold counter 0.
- Pick rule: choose the first set `req` bit at or after the `ptr` bit, searching upward by index and wrapping from N-1 to 0.
- IDLE: if `req` ≠ 0, grant the pick, clear the counter to 1 and go to GRANT. Otherwise stay idle.
- GRANT, owner `o`:
  - `req[o]` = 1 and counter < `MAX_HOLD`: hold the grant and increment the counter.
  - `req[o]` = 1, counter = `MAX_HOLD`, and another requester pending: preempt. Set `ptr` to the bit after `o`, grant the new pick, set the counter to 1 and pulse `preempt`.
  - `req[o]` = 1, counter = `MAX_HOLD`, and no other requester: keep the grant and set the counter to 1. No preempt.
  - `req[o]` = 0: release. Set `ptr` to the bit after `o`. If other requests are pending, grant the new pick in the same edge with no bubble and set the counter to 1. Otherwise clear the grant and go to IDLE.
- Simultaneous events:
  - The owner dropping `req` while another requester raises its `req` in the same cycle: the new request takes part in that edge's pick.
  - An owner that re-raises `req` after a release competes from its new ring position.
- `ptr` changes only on a release or a preempt, never in IDLE.
- Widths: the counter is clog2(`MAX_HOLD`+1) bits and saturates logically at `MAX_HOLD`. `grant_id` is the encoded value of `grant`.
- Reset mid-operation clears all state at once. A requester whose grant was cut off must re-arbitrate.

## Timing
- Latency: `req` sampled at edge k gives `grant` valid after edge k, with one cycle of latency from request to grant.
- Release: `req[o]` low sampled at edge k means `grant[o]` falls at edge k. The next owner's grant rises at the same edge.
- `preempt` is high exactly in the cycle after the preempting edge.
- `grant`, `grant_id`, `busy`, `preempt` and `ptr` are all registered. No combinational path from `req` to any output.
- Reset assertion is asynchronous. Release of reset needs no special sequencing: the first edge after release behaves as IDLE.

## Structure
- Package `ring_arb_pkg` holds:
  - the state enum, `IDLE` and `GRANT`;
  - a one-hot-to-index encode function;
  - a rotate-left-by-one function for `ptr`.
- One sub-module: `ring_pick`, a combinational masked priority picker. It takes `req`, `ptr` and an exclusion mask (the current owner, during a preempt). It returns a one-hot pick and a `found` flag.
- The top level holds the state register, counter, `ptr` and the output registers.

## Test plan
All scenarios use N=4, MAX_HOLD=4.
1. Reset: drive `rst` = 0 with `req` = 1111 → `grant` = 0000, `busy` = 0, `ptr` = 0001, `grant_id` = 0.
2. Single request: `req` = 0100 at edge 2 → `grant` = 0100 and `grant_id` = 2 after edge 2. Drop at edge 5 → `grant` = 0000 and `ptr` = 1000 after edge 5.
3. Rotation: `req` = 1111, each owner drops after 2 grant cycles and re-raises → `grant` sequence 0001, 0010, 0100, 1000, 0001, with no idle cycles between owners.
4. Preemption: `req` = 0011 held constantly → `grant` = 0001 for 4 cycles, then 0010 for 4 cycles with `preempt` pulsing once, then 0001 again.
5. Solo overrun: `req` = 1000 for 12 cycles → `grant` stays 1000 throughout, `preempt` never asserts, `ptr` unchanged.
6. Asynchronous reset mid-grant: `rst` = 0 between edges while `grant` = 0010 → outputs clear before the next edge. After release with `req` = 0010, `grant` = 0010 one edge later and `ptr` = 0001.
